// File: rtl/decoder_pkg.sv
// Shared types and widths for the held 3-to-8 decoder.
package decoder_pkg;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational binary-to-one-hot decode; bit k of onehot_o is set for code k.
module onehot_dec3to8
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [OUT_W-1:0]  onehot_o
);
  always_comb begin
    onehot_o         = '0;
    onehot_o[code_i] = 1'b1;
  end
endmodule

// File: rtl/decoder3to8_hold.sv
// 3-to-8 decoder whose registered one-hot output is held for dwell+1 cycles,
// with a ready/valid input handshake and a global enable that freezes all state.
module decoder3to8_hold
  import decoder_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [2:0]         code,
  input  logic [DWELL_W-1:0] dwell,
  output logic               in_ready,
  output logic [7:0]         w,
  output logic               out_valid,
  output logic [2:0]         code_q
);
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t              state_q, state_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]    w_q, w_d;
  logic                valid_q, valid_d;
  logic [CODE_W-1:0]   code_d;
  logic [OUT_W-1:0]    dec_onehot;
  logic                accept;

  onehot_dec3to8 u_dec (
    .code_i   (code),
    .onehot_o (dec_onehot)
  );

  assign in_ready = en && ((state_q == IDLE) || ((state_q == HOLD) && (cnt_q == '0)));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    valid_d = valid_q;
    code_d  = code_q;
    // accept already implies en, so only the HOLD countdown needs the explicit gate
    if (accept) begin
      state_d = HOLD;
      cnt_d   = dwell;
      w_d     = dec_onehot;
      valid_d = 1'b1;
      code_d  = code;
    end else if (en && (state_q == HOLD)) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        state_d = IDLE;
        w_d     = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign w         = w_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_decoder3to8_hold.sv
// Directed-vector bench for decoder3to8_hold with hand-computed expectations.
module tb_decoder3to8_hold;
  localparam int unsigned DWELL_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               in_valid;
  logic [2:0]         code;
  logic [DWELL_W-1:0] dwell;
  logic               in_ready;
  logic [7:0]         w;
  logic               out_valid;
  logic [2:0]         code_q;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  decoder3to8_hold #(.DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .code      (code),
    .dwell     (dwell),
    .in_ready  (in_ready),
    .w         (w),
    .out_valid (out_valid),
    .code_q    (code_q)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Step to one time unit past the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoder8to3: index of the set bit.
  function automatic logic [2:0] enc8to3(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic is_onehot_or_zero(input logic [7:0] v);
    return (v & (v - 8'd1)) == 8'd0;
  endfunction

  initial begin
    int unsigned cnt;
    logic [3:0]  dw;

    rst = 1'b1; en = 1'b0; in_valid = 1'b1; code = 3'd6; dwell = '0;
    tick(); tick();
    check_eq("rst_w", 32'(w), 32'h0);
    check_eq("rst_ov", 32'(out_valid), 32'h0);
    check_eq("rst_codeq", 32'(code_q), 32'h0);
    check_eq("rst_rdy_en0", 32'(in_ready), 32'h0);
    rst = 1'b0; in_valid = 1'b0;

    // en=0 in IDLE: offered code ignored
    in_valid = 1'b1; code = 3'd4;
    tick();
    check_eq("en0_noaccept", 32'(w), 32'h0);
    in_valid = 1'b0; en = 1'b1;
    #1 check_eq("idle_rdy", 32'(in_ready), 32'h1);

    // single-cycle decode, dwell=0
    in_valid = 1'b1; code = 3'd5; dwell = 4'd0;
    tick(); in_valid = 1'b0;
    check_eq("d0_w", 32'(w), 32'h20);
    check_eq("d0_ov", 32'(out_valid), 32'h1);
    check_eq("d0_codeq", 32'(code_q), 32'h5);
    check_eq("d0_rdy", 32'(in_ready), 32'h1);
    tick();
    check_eq("d0_w_after", 32'(w), 32'h0);
    check_eq("d0_ov_after", 32'(out_valid), 32'h0);

    // dwell=3: four held cycles, ready only on the last
    in_valid = 1'b1; code = 3'd3; dwell = 4'd3;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("d3_w", 32'(w), 32'h08);
      check_eq("d3_rdy", 32'(in_ready), (i == 3) ? 32'h1 : 32'h0);
      tick();
    end
    check_eq("d3_w_end", 32'(w), 32'h0);

    // back-to-back 1 then 6 with dwell=1
    in_valid = 1'b1; code = 3'd1; dwell = 4'd1;
    tick();
    check_eq("b2b_w0", 32'(w), 32'h02);
    check_eq("b2b_rdy0", 32'(in_ready), 32'h0);
    tick();
    check_eq("b2b_w1", 32'(w), 32'h02);
    check_eq("b2b_rdy1", 32'(in_ready), 32'h1);
    code = 3'd6;
    tick();
    check_eq("b2b_w2", 32'(w), 32'h40);
    tick();
    check_eq("b2b_w3", 32'(w), 32'h40);
    in_valid = 1'b0;
    tick();
    check_eq("b2b_w4", 32'(w), 32'h0);

    // en dropped 5 cycles mid-hold: code 7 dwell 4 held 10 cycles total
    in_valid = 1'b1; code = 3'd7; dwell = 4'd4;
    tick(); in_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      if (w == 8'h80) cnt++;
      en = !(c >= 2 && c < 7);
      #1;
      if (!en) check_eq("en0_rdy", 32'(in_ready), 32'h0);
      tick();
    end
    en = 1'b1;
    check_eq("en_gap_len", cnt, 32'd10);

    // reset on the 2nd held cycle aborts the hold
    in_valid = 1'b1; code = 3'd2; dwell = 4'd8;
    tick(); in_valid = 1'b0;
    tick();
    check_eq("rh_w_held", 32'(w), 32'h04);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check_eq("rh_w", 32'(w), 32'h0);
    check_eq("rh_ov", 32'(out_valid), 32'h0);
    check_eq("rh_rdy", 32'(in_ready), 32'h1);

    // reset wins over a simultaneous acceptance
    rst = 1'b1; in_valid = 1'b1; code = 3'd1; dwell = 4'd2;
    tick(); rst = 1'b0; in_valid = 1'b0;
    check_eq("rprio_w", 32'(w), 32'h0);
    check_eq("rprio_codeq", 32'(code_q), 32'h0);

    // round trip sweep through the reference encoder; code 0 uses max dwell
    for (int k = 0; k < 8; k++) begin
      dw = (k == 0) ? 4'hF : 4'(k % 3);
      in_valid = 1'b1; code = 3'(k); dwell = dw;
      cnt = 0;
      while (!in_ready && cnt < 40) begin
        tick(); cnt++;
      end
      check_eq("rt_ready_to", 32'(in_ready), 32'h1);
      tick(); in_valid = 1'b0;
      cnt = 0;
      while (out_valid && cnt < 40) begin
        check_eq("rt_enc", 32'(enc8to3(w)), 32'(code_q));
        check_eq("rt_codeq", 32'(code_q), 32'(k));
        check_eq("rt_onehot", 32'(is_onehot_or_zero(w) && (w != 8'h0)), 32'h1);
        cnt++;
        tick();
      end
      check_eq("rt_len", cnt, 32'(dw) + 32'd1);
      check_eq("rt_ov_or", 32'(out_valid), 32'(|w));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
